// File: rtl/rom_stream_reader.sv
// Streams a programmable window of a 1-cycle synchronous-read ROM onto a
// valid/ready interface, walking addresses up or down with wrap-around.
module rom_stream_reader #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              dir,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic              rom_rd_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]    DEPTH_OCC  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   FULL_BURST = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_dir;
    logic [ADDR_W:0]     r_remaining;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
    logic                r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_fifo_cnt;
    logic                r_done;

    logic                w_pop;
    logic                w_issue;
    logic                w_final_issue;
    logic [CNT_W:0]      w_occ;

    // Occupancy counts the word already in flight and credits a same-cycle pop.
    assign w_pop         = out_valid && out_ready;
    assign w_occ         = {1'b0, r_fifo_cnt} + (CNT_W + 1)'(r_inflight)
                           - (CNT_W + 1)'(w_pop);
    assign w_final_issue = w_issue && (r_remaining == (ADDR_W + 1)'(1));

    assign ADDRESS   = r_addr;
    assign out_valid = (r_fifo_cnt != '0);
    assign out_data  = r_mem_data[r_rd_ptr];
    assign out_last  = out_valid && r_mem_last[r_rd_ptr];
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StRead;
            StRead:  if (w_final_issue) w_state_next = StDrain;
            StDrain: if (w_pop && out_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_issue   = (r_state == StRead) && (w_occ < DEPTH_OCC);
        rom_rd_en = w_issue;
        busy      = (r_state != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr          <= '0;
            r_dir           <= 1'b0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_fifo_cnt      <= '0;
            r_done          <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else begin
            r_done          <= (r_state == StDrain) && w_pop && out_last;
            r_inflight      <= w_issue;
            r_inflight_last <= w_final_issue;

            if (r_state == StIdle && start) begin
                r_addr      <= start_addr;
                r_dir       <= dir;
                r_remaining <= (count == '0) ? FULL_BURST : count;
            end else if (w_issue) begin
                r_addr      <= r_dir ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W + 1)'(1);
            end

            if (r_inflight) begin
                r_mem_data[r_wr_ptr] <= rom_data;
                r_mem_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end

            unique case ({r_inflight, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: a ROM model plus a transaction-level reference
// (issued/popped beat counts against a precomputed address list).
module tb_rom_stream_reader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic              dir = 1'b0;
    logic [ADDR_W-1:0] ADDRESS;
    logic              rom_rd_en;
    logic [DATA_W-1:0] rom_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    // Reference state: a burst is a list of addresses; the DUT is described by
    // how many have been issued and how many have been handed downstream.
    bit        m_active = 0;
    bit        m_done = 0;
    int        m_n = 0;
    int        m_iss = 0;
    int        m_iss_prev = 0;
    int        m_popped = 0;
    int        exp_addr [32];

    rom_stream_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .count(count),
        .dir(dir),
        .ADDRESS(ADDRESS),
        .rom_rd_en(rom_rd_en),
        .rom_data(rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input int a);
        return DATA_W'(a + 'hA0);
    endfunction

    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom_word(int'(ADDRESS));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven by the caller at posedge+1.
    task automatic step();
        bit exp_valid, exp_rd, pop, nd, was_active;
        #2;
        exp_valid = m_active && (m_iss_prev - m_popped > 0);
        pop       = exp_valid && out_ready;
        exp_rd    = m_active && (m_iss < m_n) && (m_iss - m_popped - int'(pop) < DEPTH);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("rom_rd_en", 32'(rom_rd_en), 32'(exp_rd));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        if (exp_rd && rom_rd_en) chk("address", 32'(ADDRESS), 32'(exp_addr[m_iss]));
        if (exp_valid && out_valid) begin
            chk("out_data", 32'(out_data), 32'(rom_word(exp_addr[m_popped])));
            chk("out_last", 32'(out_last), 32'(m_popped == m_n - 1));
        end
        was_active = m_active;
        nd = 0;
        m_iss_prev = m_iss;
        if (exp_rd) m_iss++;
        if (pop) begin
            m_popped++;
            if (m_popped == m_n) begin
                m_active = 0;
                nd = 1;
            end
        end
        m_done = nd;
        if (start && !was_active) begin
            m_n = (count == 0) ? 32 : int'(count);
            for (int i = 0; i < m_n; i++)
                exp_addr[i] = (int'(start_addr) + (dir ? 32 - i : i)) % 32;
            m_active = 1;
            m_iss = 0;
            m_iss_prev = 0;
            m_popped = 0;
        end
        if (!rst) begin
            m_active = 0;
            m_done = 0;
            m_iss = 0;
            m_iss_prev = 0;
            m_popped = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_idle_inputs();
        start_addr = ADDR_W'($urandom);
        count      = (ADDR_W + 1)'($urandom);
        dir        = 1'($urandom);
    endtask

    // mode 0: ready high; 1: random ready; 2: five-cycle stall after 3 cycles
    task automatic run_burst(input int sa, input int cnt, input bit d, input int mode);
        int k;
        start      = 1'b1;
        start_addr = ADDR_W'(sa);
        count      = (ADDR_W + 1)'(cnt);
        dir        = d;
        out_ready  = (mode == 1) ? 1'($urandom) : 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (m_active && k < 300) begin
            randomize_idle_inputs();
            case (mode)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = !(k >= 3 && k < 8);
                default: out_ready = 1'b1;
            endcase
            step();
            k++;
        end
        chk("burst_timeout", 32'(m_active), 32'(0));
    endtask

    initial begin
        // Reset for two cycles with random inputs.
        rst = 1'b0;
        start = 1'($urandom);
        randomize_idle_inputs();
        out_ready = 1'($urandom);
        @(posedge clk);
        #1;
        start = 1'b1;
        step();
        start = 1'b0;
        rst = 1'b1;
        chk("rst_address", 32'(ADDRESS), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        step();

        run_burst(0, 4, 1'b0, 0);
        run_burst(30, 4, 1'b0, 0);
        run_burst(1, 3, 1'b1, 0);
        run_burst(7, 0, 1'b0, 0);
        chk("full_window_last_addr", 32'(exp_addr[31]), 32'(6));
        run_burst(5, 10, 1'b0, 2);
        run_burst(2, 6, 1'b1, 2);
        for (int i = 0; i < 8; i++)
            run_burst(int'($urandom_range(0, 31)), int'($urandom_range(0, 32)),
                      1'($urandom), 1);
        start = 1'b0;
        step();
        step();

        // Reset mid-burst, with a start attempt while busy beforehand.
        start = 1'b1; start_addr = 10; count = 20; dir = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        start = 1'b1; start_addr = 25; count = 2; dir = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        step();
        run_burst(3, 5, 1'b1, 1);
        run_burst(31, 2, 1'b0, 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
